hamming_secded_stream_decoder: RTL and testbench

Parametrised serial-in Hamming decoder, the successor to the fixed (7,4) serial decoder. Supports any data width, with optional SEC-DED using an extra overall-parity bit.
- Deserialises a bit stream into codewords, computes syndrome and overall parity, corrects single-bit errors, flags uncorrectable ones.
- Presents corrected data on a valid/ready parallel port with status and saturating error counters.
- Sits between the serial link receiver and the downstream data consumer, on one clock.

---
 rtl/hamming_secded_stream_decoder.sv | 140 ++++++++++++++
 tb/tb_hamming_secded_stream_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_stream_decoder.sv
// Serial-in Hamming SEC/SEC-DED decoder: bits arrive at positions 1..N, then position 0; words leave on valid/ready.
// Decoded word is presented one clock after its last bit; in_ready drops only while a full word waits behind a stalled output.
module hamming_secded_stream_decoder #(
  parameter int DATA_W = 4,
  parameter int SECDED = 1,
  parameter int CNT_W  = 8,
  localparam int P = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              serial_valid,
  output logic              in_ready,
  input  logic              sync_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [P-1:0]      syndrome,
  output logic              err_corrected,
  output logic              err_uncorr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam int N    = DATA_W + P;
  localparam int CW_W = N + SECDED;
  localparam int CB   = $clog2(CW_W);

  // Position of the k-th data bit: k-th index that is not a power of two.
  function automatic int data_pos(int k);
    int c;
    int r;
    c = 0;
    r = 0;
    for (int i = 3; i < 128; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (c == k) r = i;
        c++;
      end
    end
    return r;
  endfunction

  logic [CB-1:0]     bit_cnt;
  logic [N:0]        cw;
  logic              full;
  logic              load;
  logic              accept;
  logic              wrap;
  logic [P-1:0]      pos;
  logic [P-1:0]      syn_c;
  logic              par_c;
  logic              corr_c;
  logic              unc_c;
  logic              flip_c;
  logic [DATA_W-1:0] dec_c;

  assign load     = full && (!data_valid || data_ready);
  assign in_ready = !full || load;
  assign accept   = serial_valid && in_ready && !sync_clr;
  assign wrap     = accept && (bit_cnt == CB'(CW_W - 1));
  assign pos      = (SECDED != 0 && bit_cnt == CB'(N)) ? '0 : P'(bit_cnt) + P'(1);

  always_comb begin
    syn_c = '0;
    for (int i = 1; i <= N; i++) begin
      if (cw[i]) syn_c = syn_c ^ P'(i);
    end
    par_c  = ^cw;
    corr_c = 1'b0;
    unc_c  = 1'b0;
    flip_c = 1'b0;
    if (SECDED != 0) begin
      // Odd parity means an odd error count; a zero syndrome then blames position 0.
      if (par_c) begin
        if (int'(syn_c) > N) begin
          unc_c = 1'b1;
        end else begin
          corr_c = 1'b1;
          flip_c = (syn_c != '0);
        end
      end else if (syn_c != '0) begin
        unc_c = 1'b1;
      end
    end else if (syn_c != '0) begin
      if (int'(syn_c) > N) begin
        unc_c = 1'b1;
      end else begin
        corr_c = 1'b1;
        flip_c = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < DATA_W; k++) begin : g_data
    localparam int DP = data_pos(k);
    assign dec_c[k] = cw[DP] ^ (flip_c && (syn_c == P'(DP)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      cw      <= '0;
      full    <= 1'b0;
    end else begin
      if (sync_clr) begin
        bit_cnt <= '0;
        if (!full) cw <= '0;
      end else if (accept) begin
        cw[pos] <= serial_in;
        bit_cnt <= wrap ? '0 : bit_cnt + CB'(1);
      end
      if (wrap) full <= 1'b1;
      else if (load) full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      syndrome      <= '0;
      err_corrected <= 1'b0;
      err_uncorr    <= 1'b0;
      corr_cnt      <= '0;
      uncorr_cnt    <= '0;
    end else if (load) begin
      data_out      <= dec_c;
      data_valid    <= 1'b1;
      syndrome      <= syn_c;
      err_corrected <= corr_c;
      err_uncorr    <= unc_c;
      if (corr_c && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
      if (unc_c && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end else if (data_ready) begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Bench for the serial Hamming decoder: default SEC-DED(4), SEC-DED(11) and plain SEC(4) with a 2-bit counter.
module tb_hamming_secded_stream_decoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_sin, a_svld, a_rdy, a_clr, a_dvld, a_drdy, a_ec, a_eu;
  logic [3:0] a_dout;
  logic [2:0] a_syn;
  logic [7:0] a_cc, a_uc;

  logic        b_sin, b_svld, b_rdy, b_dvld, b_ec, b_eu;
  logic [10:0] b_dout;
  logic [3:0]  b_syn;
  logic [7:0]  b_cc, b_uc;

  logic       c_sin, c_svld, c_rdy, c_dvld, c_ec, c_eu;
  logic [3:0] c_dout;
  logic [2:0] c_syn;
  logic [1:0] c_cc, c_uc;

  hamming_secded_stream_decoder u_a (
    .clk(clk), .rst(rst), .serial_in(a_sin), .serial_valid(a_svld), .in_ready(a_rdy),
    .sync_clr(a_clr), .data_out(a_dout), .data_valid(a_dvld), .data_ready(a_drdy),
    .syndrome(a_syn), .err_corrected(a_ec), .err_uncorr(a_eu), .corr_cnt(a_cc), .uncorr_cnt(a_uc));

  hamming_secded_stream_decoder #(.DATA_W(11), .SECDED(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .serial_in(b_sin), .serial_valid(b_svld), .in_ready(b_rdy),
    .sync_clr(1'b0), .data_out(b_dout), .data_valid(b_dvld), .data_ready(1'b1),
    .syndrome(b_syn), .err_corrected(b_ec), .err_uncorr(b_eu), .corr_cnt(b_cc), .uncorr_cnt(b_uc));

  hamming_secded_stream_decoder #(.DATA_W(4), .SECDED(0), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .serial_in(c_sin), .serial_valid(c_svld), .in_ready(c_rdy),
    .sync_clr(1'b0), .data_out(c_dout), .data_valid(c_dvld), .data_ready(1'b1),
    .syndrome(c_syn), .err_corrected(c_ec), .err_uncorr(c_eu), .corr_cnt(c_cc), .uncorr_cnt(c_uc));

  typedef struct {
    logic [63:0] data;
    logic [63:0] syn;
    bit          corr;
    bit          unc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   a_corr_model = 0, a_unc_model = 0;
  int   b_corr_model = 0, b_unc_model = 0;
  int   c_corr_model = 0, c_unc_model = 0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(int v, int m);
    return (v > m) ? m : v;
  endfunction

  function automatic int calc_p(int dw);
    int r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  // Codeword indexed by position: data at non-power-of-two slots, parity bit 2^j covers indices with bit j set.
  function automatic logic [63:0] encode(logic [63:0] d, int dw, bit secded);
    logic [63:0] c = '0;
    int p = calc_p(dw);
    int n = dw + p;
    int k = 0;
    for (int i = 1; i <= n; i++)
      if ((i & (i - 1)) != 0) begin c[i] = d[k]; k++; end
    for (int j = 0; j < p; j++)
      for (int i = 1; i <= n; i++)
        if (((i >> j) & 1) == 1 && (i & (i - 1)) != 0) c[1 << j] = c[1 << j] ^ c[i];
    if (secded) c[0] = ^c;
    return c;
  endfunction

  function automatic logic [63:0] extract(logic [63:0] r, int dw);
    logic [63:0] d = '0;
    int k = 0;
    for (int i = 3; k < dw; i++)
      if ((i & (i - 1)) != 0) begin d[k] = r[i]; k++; end
    return d;
  endfunction

  function automatic logic [63:0] flipped(logic [63:0] d, int dw, bit secded, int e1, int e2);
    logic [63:0] r = encode(d, dw, secded);
    if (e1 >= 0) r[e1] = ~r[e1];
    if (e2 >= 0) r[e2] = ~r[e2];
    return r;
  endfunction

  // Outcome follows from how many bits were hit, not from recomputing the syndrome logic.
  function automatic exp_t predict(logic [63:0] d, int dw, bit secded, int e1, int e2);
    exp_t e;
    e.data = d; e.syn = '0; e.corr = 1'b0; e.unc = 1'b0;
    if (e1 >= 0 && e2 >= 0) begin
      e.unc  = 1'b1;
      e.syn  = 64'(e1 ^ e2);
      e.data = extract(flipped(d, dw, secded, e1, e2), dw);
    end else if (e1 >= 0) begin
      e.corr = 1'b1;
      e.syn  = 64'(e1);
    end
    return e;
  endfunction

  function automatic logic [63:0] rand_data(int dw);
    return {$urandom(), $urandom()} & ((64'd1 << dw) - 64'd1);
  endfunction

  task automatic send_bit_a(input logic b);
    int t = 0;
    a_sin = b; a_svld = 1'b1;
    if (rand_rdy) a_drdy = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    while (!a_rdy && t < 200) begin
      @(posedge clk); #1;
      if (rand_rdy) a_drdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++; errors++;
      $error("FAIL a_in_ready_timeout: observed in_ready 0, expected 1");
    end
    @(posedge clk); #1;
    a_svld = 1'b0;
  endtask

  task automatic a_word(input logic [63:0] d, input int e1, input int e2);
    logic [63:0] r = flipped(d, 4, 1'b1, e1, e2);
    exp_q.push_back(predict(d, 4, 1'b1, e1, e2));
    for (int i = 1; i <= 8; i++) send_bit_a(r[i % 8]);
  endtask

  task automatic a_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk("a_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic bc_word(input bit use_c, input logic [63:0] d, input int e1, input int e2);
    int dw, n, t;
    bit sec;
    logic [63:0] r;
    exp_t e;
    dw = use_c ? 4 : 11;
    sec = !use_c;
    n = dw + calc_p(dw);
    r = flipped(d, dw, sec, e1, e2);
    e = predict(d, dw, sec, e1, e2);
    for (int i = 1; i <= n + int'(sec); i++) begin
      if (use_c) begin c_svld = 1'b1; c_sin = r[i % (n + 1)]; end
      else begin b_svld = 1'b1; b_sin = r[i % (n + 1)]; end
      @(negedge clk);
      if (i == 1) chk(use_c ? "c_in_ready" : "b_in_ready", use_c ? c_rdy : b_rdy, 1'b1);
      @(posedge clk); #1;
    end
    b_svld = 1'b0; c_svld = 1'b0;
    t = 0;
    @(negedge clk);
    while (!(use_c ? c_dvld : b_dvld) && t < 8) begin @(negedge clk); t++; end
    if (use_c) begin
      if (e.corr) c_corr_model++;
      if (e.unc) c_unc_model++;
      chk("c_valid", c_dvld, 1'b1);
      chk("c_data", c_dout, e.data);
      chk("c_syn", c_syn, e.syn);
      chk("c_corr", c_ec, e.corr);
      chk("c_unc", c_eu, e.unc);
      chk("c_corr_cnt", c_cc, 64'(sat(c_corr_model, 3)));
    end else begin
      if (e.corr) b_corr_model++;
      if (e.unc) b_unc_model++;
      chk("b_valid", b_dvld, 1'b1);
      chk("b_data", b_dout, e.data);
      chk("b_syn", b_syn, e.syn);
      chk("b_corr", b_ec, e.corr);
      chk("b_unc", b_eu, e.unc);
      chk("b_corr_cnt", b_cc, 64'(sat(b_corr_model, 255)));
      chk("b_uncorr_cnt", b_uc, 64'(sat(b_unc_model, 255)));
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard for the default instance: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && a_dvld && a_drdy) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL a_extra_word: observed data %0h, expected no word", a_dout);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.corr) a_corr_model++;
        if (mon_e.unc) a_unc_model++;
        chk("a_data", a_dout, mon_e.data);
        chk("a_syn", a_syn, mon_e.syn);
        chk("a_corr", a_ec, mon_e.corr);
        chk("a_unc", a_eu, mon_e.unc);
        chk("a_corr_cnt", a_cc, 64'(sat(a_corr_model, 255)));
        chk("a_uncorr_cnt", a_uc, 64'(sat(a_unc_model, 255)));
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_sin = 1'b0; a_svld = 1'b0; a_clr = 1'b0; a_drdy = 1'b1;
    b_sin = 1'b0; b_svld = 1'b0; c_sin = 1'b0; c_svld = 1'b0;
    @(negedge clk);
    chk("rst_a_valid", a_dvld, 1'b0);
    chk("rst_a_data", a_dout, 4'h0);
    chk("rst_a_syn", a_syn, 3'd0);
    chk("rst_a_flags", {a_ec, a_eu}, 2'b00);
    chk("rst_a_cnts", {a_cc, a_uc}, 16'h0);
    chk("rst_b_valid", b_dvld, 1'b0);
    chk("rst_c_valid", c_dvld, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("a_in_ready_idle", a_rdy, 1'b1);
    @(posedge clk); #1;

    // Clean word 1011: exactly one cycle of latency, valid for one cycle.
    a_word(64'hB, -1, -1);
    @(negedge clk); chk("t1_not_yet", a_dvld, 1'b0);
    @(negedge clk); chk("t1_valid", a_dvld, 1'b1); chk("t1_data", a_dout, 4'hB); chk("t1_syn", a_syn, 3'd0);
    @(negedge clk); chk("t1_one_clk", a_dvld, 1'b0);
    @(posedge clk); #1;

    a_word(64'hB, 5, -1);
    @(negedge clk); @(negedge clk);
    chk("t2_data", a_dout, 4'hB); chk("t2_syn", a_syn, 3'd5); chk("t2_corr", a_ec, 1'b1); chk("t2_cc", a_cc, 8'd1);
    @(posedge clk); #1;

    a_word(64'hB, 3, 6);
    @(negedge clk); @(negedge clk);
    chk("t3_unc", a_eu, 1'b1); chk("t3_syn", a_syn, 3'd5); chk("t3_data", a_dout, 4'hE); chk("t3_uc", a_uc, 8'd1);
    @(posedge clk); #1;

    a_word(64'hB, 0, -1);
    @(negedge clk); @(negedge clk);
    chk("t4_data", a_dout, 4'hB); chk("t4_syn", a_syn, 3'd0); chk("t4_corr", a_ec, 1'b1);
    @(posedge clk); #1;

    // Backpressure: second word fills behind a stalled output.
    a_drdy = 1'b0;
    a_word(64'h6, -1, -1);
    a_word(64'h9, 2, -1);
    @(negedge clk);
    chk("bp_in_ready_low", a_rdy, 1'b0);
    chk("bp_valid", a_dvld, 1'b1);
    chk("bp_held_data", a_dout, 4'h6);
    repeat (3) @(negedge clk);
    chk("bp_still_held", a_dout, 4'h6);
    chk("bp_still_blocked", a_rdy, 1'b0);
    @(posedge clk); #1;
    a_drdy = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_on_load", a_rdy, 1'b1);
    @(posedge clk); #1;
    a_drain();

    // Realign after a partial word; the bit offered with sync_clr is dropped.
    send_bit_a(1'b1); send_bit_a(1'b1); send_bit_a(1'b0);
    a_clr = 1'b1; a_svld = 1'b1; a_sin = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0; a_svld = 1'b0;
    a_word(64'h5, -1, -1);
    a_drain();

    for (int w = 0; w < 300; w++) a_word(rand_data(4), $urandom_range(0, 7), -1);
    a_drain();
    chk("corr_cnt_saturated", a_cc, 8'd255);

    rand_rdy = 1'b1;
    for (int w = 0; w < 40; w++) begin
      int kind = $urandom_range(0, 2);
      int e1 = $urandom_range(0, 7);
      int e2 = (e1 + $urandom_range(1, 7)) % 8;
      a_word(rand_data(4), (kind == 0) ? -1 : e1, (kind == 2) ? e2 : -1);
    end
    rand_rdy = 1'b0;
    a_drdy = 1'b1;
    a_drain();
    chk("uncorr_cnt_final", a_uc, 64'(sat(a_unc_model, 255)));

    // Reset while a word is held and the next is partially received.
    a_drdy = 1'b0;
    a_word(64'h3, -1, -1);
    send_bit_a(1'b1); send_bit_a(1'b0); send_bit_a(1'b1);
    rst = 1'b1;
    exp_q.delete();
    a_corr_model = 0; a_unc_model = 0;
    @(negedge clk);
    chk("midrst_valid", a_dvld, 1'b0);
    chk("midrst_data", a_dout, 4'h0);
    chk("midrst_cnts", {a_cc, a_uc}, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0; a_drdy = 1'b1;
    a_word(64'hC, 6, -1);
    a_drain();

    bc_word(1'b0, rand_data(11), -1, -1);
    for (int e = 0; e < 16; e++) bc_word(1'b0, rand_data(11), e, -1);
    bc_word(1'b0, rand_data(11), 3, 12);

    bc_word(1'b1, rand_data(4), -1, -1);
    for (int e = 1; e <= 7; e++) bc_word(1'b1, rand_data(4), e, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
